circ_mtx_vec_mul_seq: RTL and testbench

Time-multiplexed circulant matrix-vector multiplier over GF(p), with p = 2^WORD_WIDTH - 1 (Mersenne prime, 2147483647 at the default width). The matrix is given by its first row. Rows are formed by circular right shift (mode 0) or circular left shift (mode 1), so one block serves both the MDS layer and its transpose in the hash datapath. LANES rows are computed in parallel, one multiply-accumulate per lane per cycle. Input and output use valid/ready handshakes.

---
 rtl/circ_mtx_vec_mul_seq_pkg.sv | 30 +++
 rtl/circ_mtx_vec_mul_seq_if.sv | 25 ++
 rtl/circ_mtx_vec_mul_seq_mersenne_mul.sv | 30 +++
 rtl/circ_mtx_vec_mul_seq.sv | 131 +++++++++++++
 tb/tb_circ_mtx_vec_mul_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/circ_mtx_vec_mul_seq_pkg.sv
// Shared types and GF(2^W - 1) arithmetic helpers for the circulant
// matrix-vector multiplier.
package circ_mtx_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, DONE} state_t;

  function automatic int batch_count(input int n, input int lanes);
    return n / lanes;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two folds bring any value below 2^(2w) into [0, p]; p itself maps to 0.
  function automatic logic [63:0] mod_p_fold(input logic [127:0] x, input int w);
    logic [127:0] p;
    logic [127:0] s;
    p = (128'd1 << w) - 128'd1;
    s = (x & p) + (x >> w);
    s = (s & p) + (s >> w);
    if (s == p) s = '0;
    return s[63:0];
  endfunction

  function automatic logic [63:0] mod_p_add(input logic [63:0] a, input logic [63:0] b, input int w);
    return mod_p_fold({64'd0, a} + {64'd0, b}, w);
  endfunction

endpackage

// File: rtl/circ_mtx_vec_mul_seq_if.sv
// Operand/result handshake bundle for circ_mtx_vec_mul_seq.
interface circ_mtx_vec_mul_seq_if #(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
);
  logic                                in_valid;
  logic                                in_ready;
  logic                                mode;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] mtx_row;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] vec;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] result;
  logic                                out_valid;
  logic                                out_ready;
  logic                                busy;

  modport master (
    output in_valid, mode, mtx_row, vec, out_ready,
    input  in_ready, result, out_valid, busy
  );

  modport slave (
    input  in_valid, mode, mtx_row, vec, out_ready,
    output in_ready, result, out_valid, busy
  );
endinterface

// File: rtl/circ_mtx_vec_mul_seq_mersenne_mul.sv
// One-cycle modular multiplier over GF(2^W - 1); the product is folded to
// canonical form before it is registered.
module mersenne_mul
  import circ_mtx_pkg::*;
#(
  parameter int WORD_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0] prod
);
  logic [2*WORD_WIDTH-1:0] full;
  logic [WORD_WIDTH-1:0]   prod_next;
  logic [WORD_WIDTH-1:0]   prod_reg;

  // An all-ones operand is congruent to 0, so the fold zeroes it for free.
  always_comb begin
    full      = {{WORD_WIDTH{1'b0}}, a} * {{WORD_WIDTH{1'b0}}, b};
    prod_next = WORD_WIDTH'(mod_p_fold(128'(full), WORD_WIDTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prod_reg <= '0;
    else        prod_reg <= prod_next;
  end

  assign prod = prod_reg;
endmodule

// File: rtl/circ_mtx_vec_mul_seq.sv
// Time-multiplexed circulant matrix-vector multiplier over GF(2^W - 1):
// LANES rows per batch, one multiply-accumulate per lane per cycle.
module circ_mtx_vec_mul_seq
  import circ_mtx_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16,
  parameter int LANES      = 4
) (
  input logic                  clk,
  input logic                  reset,
  circ_mtx_vec_mul_seq_if.slave bus
);
  localparam int N_BATCH = batch_count(MTX_SIZE, LANES);
  localparam int COL_W   = cnt_width(MTX_SIZE);
  localparam int BATCH_W = cnt_width(N_BATCH);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(MTX_SIZE - 1);
  localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(N_BATCH - 1);
  localparam logic [COL_W:0]     N_W        = (COL_W + 1)'(MTX_SIZE);

  if (MTX_SIZE % LANES != 0) begin : g_lane_check
    $error("MTX_SIZE must be a multiple of LANES");
  end

  typedef logic [WORD_WIDTH-1:0] word_t;

  state_t                 state_reg, state_next;
  logic                   mode_reg;
  word_t [MTX_SIZE-1:0]   row_reg;
  word_t [MTX_SIZE-1:0]   vec_reg;
  word_t [MTX_SIZE-1:0]   result_reg;
  logic [COL_W-1:0]       col_reg;
  logic [BATCH_W-1:0]     batch_reg;
  word_t                  acc_reg  [LANES];
  word_t                  coef     [LANES];
  word_t                  prod     [LANES];
  word_t                  lane_sum [LANES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = (state_reg != IDLE);
    bus.result    = result_reg;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = COMPUTE;
      end
      COMPUTE: if (col_reg == COL_LAST) state_next = DRAIN;
      DRAIN:   state_next = (batch_reg == BATCH_LAST) ? DONE : COMPUTE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [COL_W:0]   row_idx;
    logic [COL_W:0]   k_wide;
    logic [COL_W-1:0] k;

    // Circulant column index: (col - row) mod N for mode 0, (col + row) mod N for mode 1.
    always_comb begin
      row_idx = (COL_W + 1)'(int'(batch_reg) * LANES + gi);
      if (mode_reg) k_wide = {1'b0, col_reg} + row_idx;
      else          k_wide = {1'b0, col_reg} + N_W - row_idx;
      if (k_wide >= N_W) k_wide = k_wide - N_W;
      k            = k_wide[COL_W-1:0];
      coef[gi]     = row_reg[k];
      lane_sum[gi] = WORD_WIDTH'(mod_p_add(64'(acc_reg[gi]), 64'(prod[gi]), WORD_WIDTH));
    end

    mersenne_mul #(.WORD_WIDTH(WORD_WIDTH)) u_mul (
      .clk   (clk),
      .reset (reset),
      .a     (coef[gi]),
      .b     (vec_reg[col_reg]),
      .prod  (prod[gi])
    );
  end

  // The product register lags the column counter by one cycle, so column 0
  // has nothing to accumulate yet and DRAIN picks up column N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg   <= 1'b0;
      row_reg    <= '0;
      vec_reg    <= '0;
      result_reg <= '0;
      col_reg    <= '0;
      batch_reg  <= '0;
      for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            mode_reg  <= bus.mode;
            row_reg   <= bus.mtx_row;
            vec_reg   <= bus.vec;
            col_reg   <= '0;
            batch_reg <= '0;
            for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
          end
        end
        COMPUTE: begin
          col_reg <= col_reg + 1'b1;
          if (col_reg != '0) begin
            for (int l = 0; l < LANES; l++) acc_reg[l] <= lane_sum[l];
          end
        end
        DRAIN: begin
          for (int r = 0; r < MTX_SIZE; r++) begin
            if (r / LANES == int'(batch_reg)) result_reg[r] <= lane_sum[r % LANES];
          end
          for (int l = 0; l < LANES; l++) acc_reg[l] <= '0;
          col_reg <= '0;
          if (batch_reg != BATCH_LAST) batch_reg <= batch_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_circ_mtx_vec_mul_seq.sv
// Bench for circ_mtx_vec_mul_seq: directed N=4/LANES=2 cases plus a random
// N=16 regression over LANES 1, 4 and 16 against a plain GF(p) model.
module tb_circ_mtx_vec_mul_seq;
  localparam int          W  = 31;
  localparam logic [63:0] P  = 64'h7fff_ffff;
  localparam int          BN = 16;

  typedef logic [3:0][W-1:0]    vec4_t;
  typedef logic [BN-1:0][W-1:0] vec16_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Small directed instance
  circ_mtx_vec_mul_seq_if #(.WORD_WIDTH(W), .MTX_SIZE(4)) sb ();
  circ_mtx_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(4), .LANES(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sb.slave)
  );

  // Three N=16 instances sharing one stimulus, LANES = 1, 4, 16
  logic   bin_valid, bmode, bout_ready;
  vec16_t brow, bvec;
  logic   bout_valid [3];
  logic   bin_ready  [3];
  vec16_t bres       [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_big
    circ_mtx_vec_mul_seq_if #(.WORD_WIDTH(W), .MTX_SIZE(BN)) bb ();
    circ_mtx_vec_mul_seq #(.WORD_WIDTH(W), .MTX_SIZE(BN), .LANES(1 << (2 * gi))) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bb.slave)
    );
    assign bb.in_valid   = bin_valid;
    assign bb.mode       = bmode;
    assign bb.mtx_row    = brow;
    assign bb.vec        = bvec;
    assign bb.out_ready  = bout_ready;
    assign bout_valid[gi] = bb.out_valid;
    assign bin_ready[gi]  = bb.in_ready;
    assign bres[gi]       = bb.result;
  end

  function automatic vec4_t mk4(input logic [63:0] e0, input logic [63:0] e1,
                                input logic [63:0] e2, input logic [63:0] e3);
    vec4_t r;
    r[0] = W'(e0); r[1] = W'(e1); r[2] = W'(e2); r[3] = W'(e3);
    return r;
  endfunction

  function automatic logic [63:0] rnd_word();
    case ($urandom_range(0, 7))
      0:       return P;
      1:       return P - 64'd1;
      2:       return 64'd0;
      default: return 64'($urandom) & P;
    endcase
  endfunction

  // Reference: build each matrix element from the first row and sum products mod p.
  function automatic void ref_mul(input int n, input bit md, input logic [63:0] row [BN],
                                  input logic [63:0] v [BN], output logic [63:0] res [BN]);
    longint unsigned acc;
    int k;
    for (int r = 0; r < BN; r++) res[r] = 64'd0;
    for (int r = 0; r < n; r++) begin
      acc = 0;
      for (int j = 0; j < n; j++) begin
        k   = md ? (j + r) % n : (j - r + n) % n;
        acc = (acc + (row[k] % P) * (v[j] % P)) % P;
      end
      res[r] = acc;
    end
  endfunction

  task automatic s_start(input bit md, input vec4_t row, input vec4_t v, output int waited);
    sb.in_valid = 1'b1;
    sb.mode     = md;
    sb.mtx_row  = row;
    sb.vec      = v;
    waited      = 0;
    while (sb.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_wait_bounded", 64'(waited < 100), 64'd1);
    @(posedge clk); #1;
    sb.in_valid = 1'b0;
    sb.mode     = ~md;
    for (int i = 0; i < 4; i++) begin
      sb.mtx_row[i] = W'($urandom);
      sb.vec[i]     = W'($urandom);
    end
  endtask

  task automatic s_finish_job(input string tag, input vec4_t exp);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        chk({tag, "_busy"}, 64'(sb.busy), 64'd1);
        chk({tag, "_in_ready_busy"}, 64'(sb.in_ready), 64'd0);
        sb.in_valid = 1'b1;
      end
      if (lat == 4) sb.in_valid = 1'b0;
    end while (sb.out_valid !== 1'b1 && lat < 200);
    chk({tag, "_latency"}, 64'(lat), 64'd10);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_res%0d", tag, i), 64'(sb.result[i]), 64'(exp[i]));
    $display("job %s: latency=%0d result=%0d,%0d,%0d,%0d", tag, lat,
             sb.result[0], sb.result[1], sb.result[2], sb.result[3]);
  endtask

  task automatic s_release(input string tag);
    sb.out_ready = 1'b1;
    @(posedge clk); #1;
    sb.out_ready = 1'b0;
    chk({tag, "_rel_out_valid"}, 64'(sb.out_valid), 64'd0);
    chk({tag, "_rel_in_ready"}, 64'(sb.in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    bit          stable;
    bit          md;
    vec4_t       saved;
    logic [63:0] rrow [BN];
    logic [63:0] rvec [BN];
    logic [63:0] rexp [BN];
    bit          seen [3];
    int          lat  [3];
    int          cyc;

    sb.in_valid = 1'b0; sb.mode = 1'b0; sb.mtx_row = '0; sb.vec = '0; sb.out_ready = 1'b0;
    bin_valid = 1'b0; bmode = 1'b0; brow = '0; bvec = '0; bout_ready = 1'b0;

    #12;
    chk("rst_in_ready", 64'(sb.in_ready), 64'd1);
    chk("rst_out_valid", 64'(sb.out_valid), 64'd0);
    chk("rst_busy", 64'(sb.busy), 64'd0);
    chk("rst_result", 64'(sb.result == '0), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Identity, then hold the result with out_ready low
    s_start(1'b0, mk4(1, 0, 0, 0), mk4(5, 6, 7, 8), w);
    s_finish_job("ident", mk4(5, 6, 7, 8));
    stable = 1'b1;
    saved  = sb.result;
    repeat (20) begin
      @(posedge clk); #1;
      if (sb.out_valid !== 1'b1 || sb.in_ready !== 1'b0 || sb.result !== saved) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    s_release("ident");
    chk("kept_after_idle", 64'(sb.result[3]), 64'd8);

    // Shift matrix in both modes, second job issued back-to-back
    s_start(1'b0, mk4(0, 1, 0, 0), mk4(5, 6, 7, 8), w);
    s_finish_job("shift_m0", mk4(6, 7, 8, 5));
    sb.out_ready = 1'b1;
    s_start(1'b1, mk4(0, 1, 0, 0), mk4(5, 6, 7, 8), w);
    sb.out_ready = 1'b0;
    chk("b2b_wait", 64'(w), 64'd1);
    s_finish_job("shift_m1", mk4(6, 5, 8, 7));
    s_release("shift_m1");

    s_start(1'b0, mk4(P - 1, 0, 0, 0), mk4(P - 1, 1, 2, 3), w);
    s_finish_job("modprod", mk4(1, P - 1, P - 2, P - 3));
    s_release("modprod");

    // Abort at batch 1, column 2
    s_start(1'b0, mk4(1, 0, 0, 0), mk4(1, 2, 3, 4), w);
    repeat (7) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(sb.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 64'(sb.out_valid), 64'd0);
    chk("abort_in_ready", 64'(sb.in_ready), 64'd1);
    chk("abort_busy", 64'(sb.busy), 64'd0);
    chk("abort_result", 64'(sb.result == '0), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    sb.out_ready = 1'b1;
    @(posedge clk); #1;
    sb.out_ready = 1'b0;
    chk("idle_out_ready_in_ready", 64'(sb.in_ready), 64'd1);
    chk("idle_out_ready_out_valid", 64'(sb.out_valid), 64'd0);

    s_start(1'b0, mk4(1, 1, 1, 1), mk4(P - 1, P - 1, 1, 1), w);
    s_finish_job("accwrap", mk4(0, 0, 0, 0));
    s_release("accwrap");

    s_start(1'b0, mk4(1, 0, 0, 0), mk4(P, 0, 0, 0), w);
    s_finish_job("noncanon", mk4(0, 0, 0, 0));
    s_release("noncanon");

    // Random regression at N=16
    for (int job = 0; job < 6; job++) begin
      md = 1'($urandom_range(0, 1));
      for (int i = 0; i < BN; i++) begin
        rrow[i] = rnd_word();
        rvec[i] = rnd_word();
        brow[i] = W'(rrow[i]);
        bvec[i] = W'(rvec[i]);
      end
      ref_mul(BN, md, rrow, rvec, rexp);
      for (int i = 0; i < 3; i++) chk($sformatf("rnd%0d_ready_l%0d", job, i), 64'(bin_ready[i]), 64'd1);
      bmode = md;
      bin_valid = 1'b1;
      @(posedge clk); #1;
      bin_valid = 1'b0;
      for (int i = 0; i < BN; i++) begin
        brow[i] = W'($urandom);
        bvec[i] = W'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
        seen[i] = 1'b0;
        lat[i]  = 0;
      end
      cyc = 0;
      while (!(seen[0] && seen[1] && seen[2]) && cyc < 400) begin
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
          if (!seen[i] && bout_valid[i] === 1'b1) begin
            seen[i] = 1'b1;
            lat[i]  = cyc;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rnd%0d_lat_l%0d", job, i), 64'(lat[i]), 64'((BN / (1 << (2 * i))) * (BN + 1)));
        for (int r = 0; r < BN; r++)
          chk($sformatf("rnd%0d_l%0d_res%0d", job, i, r), 64'(bres[i][r]), rexp[r]);
      end
      $display("rnd job %0d: mode=%0d lat=%0d/%0d/%0d res0=%0d", job, md,
               lat[0], lat[1], lat[2], bres[0][0]);
      bout_ready = 1'b1;
      @(posedge clk); #1;
      bout_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
